// File: rtl/gnr_attractor_ctrl_pkg.sv
// Shared widths and FSM state type for the attractor sweep controller.
// Optional macro GNR_PERIOD_EN adds the PSTEP/PCMP period-measurement states.
package gnr_ctrl_pkg;

  localparam int unsigned N_NODES_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP,
    CMP,
`ifdef GNR_PERIOD_EN
    PSTEP,
    PCMP,
`endif
    OUT,
    NEXT
  } gnr_state_t;

endpackage

// File: rtl/gnr_attractor_ctrl_if.sv
// Control/result bundle between the sweep controller (slave side) and the
// node network plus result consumer (master side).
interface gnr_attractor_ctrl_if
  import gnr_ctrl_pkg::*;
#(
  parameter int unsigned N_NODES = N_NODES_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
);

  logic               start;
  logic [N_NODES-1:0] init_first;
  logic [N_NODES-1:0] init_last;
  logic [CNT_W-1:0]   max_steps;

  logic               reset_nos;
  logic               start_s0;
  logic               start_s1;
  logic [N_NODES-1:0] init_state;

  logic [N_NODES-1:0] s0_vec;
  logic [N_NODES-1:0] s1_vec;

  logic               res_valid;
  logic [N_NODES-1:0] res_init;
  logic [CNT_W-1:0]   res_transient;
  logic [CNT_W-1:0]   res_period;
  logic               res_timeout;
  logic               res_ready;
  logic               busy;
  logic               done;

  modport master (
    output start, init_first, init_last, max_steps,
    output s0_vec, s1_vec, res_ready,
    input  reset_nos, start_s0, start_s1, init_state,
    input  res_valid, res_init, res_transient, res_period, res_timeout,
    input  busy, done
  );

  modport slave (
    input  start, init_first, init_last, max_steps,
    input  s0_vec, s1_vec, res_ready,
    output reset_nos, start_s0, start_s1, init_state,
    output res_valid, res_init, res_transient, res_period, res_timeout,
    output busy, done
  );

endinterface

// File: rtl/gnr_attractor_ctrl_step_counter.sv
// Saturating step counter with a ">= limit" flag; a limit of 0 acts as 1.
module gnr_step_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  logic [CNT_W-1:0] limit_eff;

  always_comb begin
    limit_eff = (limit == '0) ? CNT_W'(1) : limit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign at_limit = (count >= limit_eff);

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Sweeps initial states, steps two node copies (s1 runs at double rate) until
// they meet, then optionally measures the cycle length (GNR_PERIOD_EN).
module gnr_attractor_ctrl
  import gnr_ctrl_pkg::*;
#(
  parameter int unsigned N_NODES = N_NODES_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  gnr_attractor_ctrl_if.slave bus
);

  gnr_state_t         state_q, state_d;
  logic [N_NODES-1:0] cur_q, last_q;
  logic [CNT_W-1:0]   max_q;
  logic [CNT_W-1:0]   trans_q;
  logic               to_q;

  logic               steps_clr, steps_inc, steps_lim;
  logic [CNT_W-1:0]   steps_cnt;
  logic               cap_trans, set_to;
  logic               vec_eq;

  assign vec_eq = (bus.s0_vec == bus.s1_vec);

  gnr_step_counter #(.CNT_W(CNT_W)) u_steps (
    .clk      (clk),
    .rst      (rst),
    .clr      (steps_clr),
    .inc      (steps_inc),
    .limit    (max_q),
    .count    (steps_cnt),
    .at_limit (steps_lim)
  );

`ifdef GNR_PERIOD_EN
  logic               per_clr, per_inc, per_lim, cap_per;
  logic [CNT_W-1:0]   per_cnt;
  logic [CNT_W-1:0]   per_q;

  gnr_step_counter #(.CNT_W(CNT_W)) u_period (
    .clk      (clk),
    .rst      (rst),
    .clr      (per_clr),
    .inc      (per_inc),
    .limit    (max_q),
    .count    (per_cnt),
    .at_limit (per_lim)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    steps_clr = 1'b0;
    steps_inc = 1'b0;
    cap_trans = 1'b0;
    set_to    = 1'b0;
`ifdef GNR_PERIOD_EN
    per_clr   = 1'b0;
    per_inc   = 1'b0;
    cap_per   = 1'b0;
`endif
    unique case (state_q)
      IDLE: if (bus.start) state_d = LOAD;
      LOAD: begin
        steps_clr = 1'b1;
`ifdef GNR_PERIOD_EN
        per_clr   = 1'b1;
`endif
        state_d   = STEP;
      end
      STEP: begin
        steps_inc = 1'b1;
        state_d   = CMP;
      end
      // Equality takes priority over the limit so a meeting on the last step counts.
      CMP: begin
        if (vec_eq) begin
          cap_trans = 1'b1;
`ifdef GNR_PERIOD_EN
          state_d   = PSTEP;
`else
          state_d   = OUT;
`endif
        end else if (steps_lim) begin
          set_to  = 1'b1;
          state_d = OUT;
        end else begin
          state_d = STEP;
        end
      end
`ifdef GNR_PERIOD_EN
      PSTEP: begin
        per_inc = 1'b1;
        state_d = PCMP;
      end
      PCMP: begin
        if (vec_eq) begin
          cap_per = 1'b1;
          state_d = OUT;
        end else if (per_lim) begin
          set_to  = 1'b1;
          state_d = OUT;
        end else begin
          state_d = PSTEP;
        end
      end
`endif
      OUT:  if (bus.res_ready) state_d = NEXT;
      NEXT: state_d = (cur_q == last_q) ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q   <= '0;
      last_q  <= '0;
      max_q   <= '0;
      trans_q <= '0;
      to_q    <= 1'b0;
    end else begin
      if ((state_q == IDLE) && bus.start) begin
        cur_q  <= bus.init_first;
        last_q <= bus.init_last;
        max_q  <= bus.max_steps;
      end
      if ((state_q == NEXT) && (cur_q != last_q)) cur_q <= cur_q + N_NODES'(1);
      if (state_q == LOAD) begin
        trans_q <= '0;
        to_q    <= 1'b0;
      end
      if (cap_trans) trans_q <= steps_cnt;
      if (set_to)    to_q    <= 1'b1;
    end
  end

`ifdef GNR_PERIOD_EN
  always_ff @(posedge clk) begin
    if (rst)                  per_q <= '0;
    else if (state_q == LOAD) per_q <= '0;
    else if (cap_per)         per_q <= per_cnt;
  end
  assign bus.res_period = per_q;
  assign bus.start_s1   = (state_q == STEP) || (state_q == PSTEP);
`else
  assign bus.res_period = '0;
  assign bus.start_s1   = (state_q == STEP);
`endif

  assign bus.busy          = (state_q != IDLE);
  assign bus.reset_nos     = (state_q == LOAD);
  assign bus.init_state    = (state_q == LOAD) ? cur_q : '0;
  assign bus.start_s0      = (state_q == STEP);
  assign bus.res_valid     = (state_q == OUT);
  assign bus.res_init      = cur_q;
  assign bus.res_transient = trans_q;
  assign bus.res_timeout   = to_q;
  assign bus.done          = (state_q == NEXT) && (cur_q == last_q);

endmodule
